alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 62 ++++++
 tb/tb_alu.sv | 107 ++++++++++
 2 files changed

// File: rtl/alu.sv
// Single-cycle registered ALU: arithmetic, bitwise logic, shifts and rotates on
// two 8-bit operands, selected by a 4-bit opcode and loaded into O every edge.
module alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] O,
  input  logic [3:0]        CTR,
  input  logic              ck,
  input  logic              rst
);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b1000,
    OP_OR  = 4'b1001,
    OP_XOR = 4'b1010,
    OP_NOT = 4'b1011,
    OP_SHL = 4'b1100,
    OP_ASR = 4'b1101,
    OP_ROL = 4'b1110,
    OP_ROR = 4'b1111
  } op_e;

  logic [DATA_W-1:0] o_d;
  logic [DATA_W-1:0] o_q;

  // Arithmetic shift keeps the sign bit; both operands are treated as raw bit vectors.
  function automatic logic [DATA_W-1:0] asr1(input logic [DATA_W-1:0] a);
    logic signed [DATA_W-1:0] s;
    s = signed'(a);
    return DATA_W'(s >>> 1);
  endfunction

  always_comb begin
    o_d = '0;
    case (CTR)
      OP_ADD:  o_d = A + B;
      OP_SUB:  o_d = A - B;
      OP_AND:  o_d = A & B;
      OP_OR:   o_d = A | B;
      OP_XOR:  o_d = A ^ B;
      OP_NOT:  o_d = ~A;
      OP_SHL:  o_d = {A[DATA_W-2:0], 1'b0};
      OP_ASR:  o_d = asr1(A);
      OP_ROL:  o_d = {A[DATA_W-2:0], A[DATA_W-1]};
      OP_ROR:  o_d = {A[0], A[DATA_W-1:1]};
      default: o_d = '0;  // reserved opcodes 0010-0111
    endcase
  end

  // Result register: the only state in the block.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) o_q <= '0;
    else     o_q <= o_d;
  end

  assign O = o_q;

endmodule

// File: tb/tb_alu.sv
// Directed bench for the registered ALU: hand-computed vectors for every opcode,
// wrap-around, sign handling, latency and asynchronous reset behaviour.
module tb_alu;

  logic [7:0] A, B, O;
  logic [3:0] CTR;
  logic       ck, rst;

  int n_cmp  = 0;
  int n_fail = 0;

  alu dut (.A(A), .B(B), .O(O), .CTR(CTR), .ck(ck), .rst(rst));

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [7:0] exp);
    n_cmp++;
    assert (O === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, O, exp);
    end
  endtask

  // Drive operands away from the edge, then sample just after the next rising edge.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                      input logic [7:0] exp, input string tag);
    @(negedge ck);
    A = a; B = b; CTR = c;
    @(posedge ck);
    #1;
    check(tag, exp);
  endtask

  initial begin
    rst = 1'b1; A = 8'hA5; B = 8'h3C; CTR = 4'b1001;
    #1;
    check("reset_async", 8'h00);
    repeat (3) @(posedge ck);
    #1;
    check("reset_held", 8'h00);

    @(negedge ck);
    rst = 1'b0;
    A = 8'd11; B = 8'd2; CTR = 4'b0000;
    @(posedge ck);
    #1;
    check("first_after_reset_add", 8'b0000_1101);

    step(8'd11,  8'd2,  4'b0001, 8'b0000_1001, "sub_11_2");
    step(8'd2,   8'd11, 4'b0001, 8'hF7,        "sub_borrow");
    step(8'hFF,  8'd1,  4'b0000, 8'h00,        "add_wrap");
    step(8'h80,  8'h80, 4'b0000, 8'h00,        "add_wrap_msb");
    step(8'h7F,  8'h01, 4'b0000, 8'h80,        "add_7f_1");

    step(8'b1001_0110, 8'b0000_1111, 4'b1000, 8'b0000_0110, "and");
    step(8'b1001_0110, 8'b0000_1111, 4'b1001, 8'b1001_1111, "or");
    step(8'b1001_0110, 8'b0000_1111, 4'b1010, 8'b1001_1001, "xor");
    step(8'b1001_0110, 8'h00,        4'b1011, 8'b0110_1001, "not");
    step(8'b1001_0110, 8'hFF,        4'b1011, 8'b0110_1001, "not_b_ignored");

    step(8'b1001_0110, 8'h00, 4'b1100, 8'b0010_1100, "shl");
    step(8'b1001_0110, 8'h00, 4'b1101, 8'b1100_1011, "asr_neg");
    step(8'b1001_0110, 8'h00, 4'b1110, 8'b0010_1101, "rol");
    step(8'b1001_0110, 8'h00, 4'b1111, 8'b0100_1011, "ror");
    step(8'b0110_0011, 8'h00, 4'b1101, 8'b0011_0001, "asr_pos");
    step(8'b0110_0011, 8'h55, 4'b1111, 8'b1011_0001, "ror_b_ignored");

    step(8'hFF, 8'hFF, 4'b1001, 8'hFF, "or_ones");
    step(8'hFF, 8'hFF, 4'b0101, 8'h00, "reserved_0101");
    step(8'hFF, 8'hFF, 4'b1001, 8'hFF, "or_ones_again");
    step(8'hFF, 8'hFF, 4'b0010, 8'h00, "reserved_0010");
    step(8'h12, 8'h34, 4'b0000, 8'h46, "add_12_34");
    step(8'h12, 8'h34, 4'b0111, 8'h00, "reserved_0111");

    // Mid-cycle input change must not reach O before the next rising edge.
    step(8'h0F, 8'hF0, 4'b1010, 8'hFF, "xor_pre_latency");
    @(negedge ck);
    A = 8'h01; B = 8'h01; CTR = 4'b0000;
    #2;
    check("latency_hold", 8'hFF);
    @(posedge ck);
    #1;
    check("latency_update", 8'h02);

    // Reset between edges clears O at once and holds through edges.
    step(8'hC3, 8'h00, 4'b1011, 8'h3C, "not_pre_reset");
    @(negedge ck);
    #1;
    rst = 1'b1;
    #1;
    check("reset_mid_cycle", 8'h00);
    A = 8'h55; B = 8'h22; CTR = 4'b0000;
    repeat (2) @(posedge ck);
    #1;
    check("reset_held_edges", 8'h00);
    @(negedge ck);
    rst = 1'b0;
    @(posedge ck);
    #1;
    check("first_after_rereset", 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
